data_memory_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage and the debug/loader port. Each cycle it grants at most one requester, drives the memory's write-enable, access-size, address and write-data inputs, and routes synchronous read data back to the owner. The pipeline has priority. A starvation counter guarantees the debug port forward progress, and a bounded lock mode gives it back-to-back burst access. The block sits between the MEM stage and `data_memory`; the pipeline sees it only through a stall.

---
 rtl/data_memory_arbiter_if.sv | 50 +++++
 rtl/data_memory_arbiter.sv | 139 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// Bundle of pipeline, debug-port and data-memory signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: carried by P_Stall / D_Gnt inside the bundle.
interface data_memory_arbiter_if;
  logic        P_Req;
  logic        P_W_En;
  logic [2:0]  P_Control;
  logic [31:0] P_Addr;
  logic [31:0] P_W_Data;
  logic        P_Stall;
  logic        P_R_Valid;
  logic [31:0] P_R_Data;

  logic        D_Req;
  logic        D_W_En;
  logic [2:0]  D_Control;
  logic [31:0] D_Addr;
  logic [31:0] D_W_Data;
  logic        D_Lock;
  logic        D_Gnt;
  logic        D_R_Valid;
  logic [31:0] D_R_Data;

  logic        Addr_Err;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_W_Data;
  logic [31:0] MEM_R_Data;

  // Arbiter side
  modport slave (
    input  P_Req, P_W_En, P_Control, P_Addr, P_W_Data,
    output P_Stall, P_R_Valid, P_R_Data,
    input  D_Req, D_W_En, D_Control, D_Addr, D_W_Data, D_Lock,
    output D_Gnt, D_R_Valid, D_R_Data,
    output Addr_Err, MEM_W_En, MEM_Control, MEM_Addr, MEM_W_Data,
    input  MEM_R_Data
  );

  // Requester / memory side
  modport master (
    output P_Req, P_W_En, P_Control, P_Addr, P_W_Data,
    input  P_Stall, P_R_Valid, P_R_Data,
    output D_Req, D_W_En, D_Control, D_Addr, D_W_Data, D_Lock,
    input  D_Gnt, D_R_Valid, D_R_Data,
    input  Addr_Err, MEM_W_En, MEM_Control, MEM_Addr, MEM_W_Data,
    output MEM_R_Data
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between pipeline (priority) and debug port.
// Latency: grant same cycle, store commits next edge, load data 1 cycle after grant.
// Backpressure: pipeline sees P_Stall, debug sees D_Gnt; requesters hold inputs while denied.
module data_memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16,
  parameter int DEPTH        = 256
) (
  input  logic                 CLK,
  input  logic                 RST,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic {P_OWN, D_LOCK} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_P, RD_D} owner_t;

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic [4:0]  r_lock_cnt;
  logic        r_p_first;     // pipeline gets the slot right after a lock-limit exit
  owner_t      r_rd_owner;
  logic        r_rd_oor;
  logic        r_addr_err;

  logic        w_p_win;
  logic        w_d_win;
  logic        w_win_oor;
  logic        w_starved;
  logic        w_lock_last;

  assign w_starved   = (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_lock_last = ((r_lock_cnt + 5'd1) == 5'(LOCK_MAX));

  // Pick the winner; nothing is granted while reset is asserted so all outputs read 0.
  always_comb begin
    w_p_win = 1'b0;
    w_d_win = 1'b0;
    if (RST) begin
      if (r_state == D_LOCK) begin
        w_d_win = bus.D_Req;
      end else if (r_p_first && bus.P_Req) begin
        w_p_win = 1'b1;
      end else begin
        w_d_win = bus.D_Req & (~bus.P_Req | w_starved);
        w_p_win = bus.P_Req & ~w_d_win;
      end
    end
  end

  // Route the winner's fields to the memory; out-of-range stores are suppressed.
  always_comb begin
    bus.MEM_W_En    = 1'b0;
    bus.MEM_Control = 3'd0;
    bus.MEM_Addr    = 32'd0;
    bus.MEM_W_Data  = 32'd0;
    w_win_oor       = 1'b0;
    if (w_p_win) begin
      w_win_oor       = (bus.P_Addr >= 32'(DEPTH));
      bus.MEM_W_En    = bus.P_W_En & ~w_win_oor;
      bus.MEM_Control = bus.P_Control;
      bus.MEM_Addr    = bus.P_Addr;
      bus.MEM_W_Data  = bus.P_W_Data;
    end else if (w_d_win) begin
      w_win_oor       = (bus.D_Addr >= 32'(DEPTH));
      bus.MEM_W_En    = bus.D_W_En & ~w_win_oor;
      bus.MEM_Control = bus.D_Control;
      bus.MEM_Addr    = bus.D_Addr;
      bus.MEM_W_Data  = bus.D_W_Data;
    end
  end

  assign bus.P_Stall   = bus.P_Req & RST & ~w_p_win;
  assign bus.D_Gnt     = w_d_win;
  assign bus.Addr_Err  = r_addr_err;
  assign bus.P_R_Valid = (r_rd_owner == RD_P);
  assign bus.D_R_Valid = (r_rd_owner == RD_D);
  assign bus.P_R_Data  = (r_rd_owner == RD_P && !r_rd_oor) ? bus.MEM_R_Data : 32'd0;
  assign bus.D_R_Data  = (r_rd_owner == RD_D && !r_rd_oor) ? bus.MEM_R_Data : 32'd0;

  // Ownership FSM with starvation counter and bounded debug lock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= P_OWN;
      r_starve_cnt <= 4'd0;
      r_lock_cnt   <= 5'd0;
      r_p_first    <= 1'b0;
    end else begin
      r_p_first <= 1'b0;
      if (!bus.D_Req || w_d_win) begin
        r_starve_cnt <= 4'd0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      case (r_state)
        P_OWN: begin
          if (w_d_win && bus.D_Lock) begin
            if (LOCK_MAX == 1) begin
              r_p_first <= 1'b1;
            end else begin
              r_state    <= D_LOCK;
              r_lock_cnt <= 5'd1;
            end
          end
        end
        default: begin
          if (w_d_win && bus.D_Lock) begin
            r_lock_cnt <= r_lock_cnt + 5'd1;
            if (w_lock_last) begin
              r_state   <= P_OWN;
              r_p_first <= 1'b1;
            end
          end else begin
            r_state <= P_OWN;
          end
        end
      endcase
    end
  end

  // Remember who owns the load in flight and whether it was out of range.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_owner <= RD_NONE;
      r_rd_oor   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_p_win && !bus.P_W_En) begin
        r_rd_owner <= RD_P;
      end else if (w_d_win && !bus.D_W_En) begin
        r_rd_owner <= RD_D;
      end else begin
        r_rd_owner <= RD_NONE;
      end
      r_rd_oor   <= w_win_oor;
      r_addr_err <= (w_p_win | w_d_win) & w_win_oor;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic against a cycle model.
// Latency: checks every cycle at the falling edge.
// Backpressure: requesters hold their fields while denied.
module tb_data_memory_arbiter;
  localparam int SL    = 4;
  localparam int LM    = 16;
  localparam int DEPTH = 256;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  data_memory_arbiter_if bus ();

  data_memory_arbiter #(.STARVE_LIMIT(SL), .LOCK_MAX(LM), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Behavioural data memory: synchronous read, garbage beyond DEPTH.
  bit [31:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (bus.MEM_W_En) mem[bus.MEM_Addr[7:0]] <= bus.MEM_W_Data;
    bus.MEM_R_Data <= (bus.MEM_Addr < DEPTH) ? mem[bus.MEM_Addr[7:0]] : 32'hDEAD_BEEF;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [31:0] gold [DEPTH];
  int        m_starve = 0;
  int        m_lock_n = 0;
  bit        m_locked = 0;
  bit        m_pfirst = 0;
  int        pend_who = 0;   // 0 none, 1 pipeline, 2 debug
  logic [31:0] pend_data = 0;
  bit        m_err = 0;

  // Observations from the latest cycle, for scenario-level checks
  bit          obs_dgnt, obs_pstall, exp_pstall, exp_ddenied;
  logic [31:0] obs_prdata, obs_drdata;
  bit          obs_prvld, obs_drvld, obs_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_p(input bit req, input bit wen, input logic [31:0] addr, input logic [31:0] data);
    bus.P_Req = req; bus.P_W_En = wen; bus.P_Addr = addr; bus.P_W_Data = data; bus.P_Control = 3'b010;
  endtask

  task automatic set_d(input bit req, input bit wen, input bit lock, input logic [31:0] addr, input logic [31:0] data);
    bus.D_Req = req; bus.D_W_En = wen; bus.D_Lock = lock; bus.D_Addr = addr; bus.D_W_Data = data; bus.D_Control = 3'b010;
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic tick();
    bit pw, dw, oor, pf_next, wen;
    logic [31:0] a, wd;
    logic [2:0]  ctl;
    @(negedge CLK);
    if (!RST) begin
      m_starve = 0; m_lock_n = 0; m_locked = 0; m_pfirst = 0;
      pend_who = 0; pend_data = 0; m_err = 0;
    end
    pw = 0; dw = 0;
    if (RST) begin
      if (m_locked) dw = bus.D_Req;
      else if (m_pfirst && bus.P_Req) pw = 1;
      else if (bus.D_Req && (!bus.P_Req || m_starve == SL)) dw = 1;
      else pw = bus.P_Req;
    end
    a = 0; wd = 0; ctl = 0; wen = 0;
    if (pw) begin a = bus.P_Addr; wd = bus.P_W_Data; ctl = bus.P_Control; wen = bus.P_W_En; end
    if (dw) begin a = bus.D_Addr; wd = bus.D_W_Data; ctl = bus.D_Control; wen = bus.D_W_En; end
    oor = (pw || dw) && (a >= DEPTH);

    chk("p_stall",  bus.P_Stall,     RST && bus.P_Req && !pw);
    chk("d_gnt",    bus.D_Gnt,       dw);
    chk("mem_wen",  bus.MEM_W_En,    wen && !oor);
    chk("mem_addr", bus.MEM_Addr,    a);
    chk("mem_wdat", bus.MEM_W_Data,  wd);
    chk("mem_ctl",  bus.MEM_Control, ctl);
    chk("p_rvld",   bus.P_R_Valid,   pend_who == 1);
    chk("p_rdat",   bus.P_R_Data,    (pend_who == 1) ? pend_data : 32'd0);
    chk("d_rvld",   bus.D_R_Valid,   pend_who == 2);
    chk("d_rdat",   bus.D_R_Data,    (pend_who == 2) ? pend_data : 32'd0);
    chk("addr_err", bus.Addr_Err,    m_err);

    obs_dgnt = bus.D_Gnt; obs_pstall = bus.P_Stall;
    obs_prdata = bus.P_R_Data; obs_drdata = bus.D_R_Data;
    obs_prvld = bus.P_R_Valid; obs_drvld = bus.D_R_Valid; obs_err = bus.Addr_Err;
    exp_pstall = RST && bus.P_Req && !pw;
    exp_ddenied = RST && bus.D_Req && !dw;

    if (RST) begin
      pend_who = 0;
      if (pw && !bus.P_W_En) pend_who = 1;
      if (dw && !bus.D_W_En) pend_who = 2;
      pend_data = oor ? 32'd0 : gold[a[7:0]];
      if ((pw || dw) && wen && !oor) gold[a[7:0]] = wd;
      m_err = oor;
      if (!bus.D_Req || dw) m_starve = 0;
      else if (m_starve < SL) m_starve++;
      pf_next = 0;
      if (m_locked) begin
        if (dw && bus.D_Lock) begin
          m_lock_n++;
          if (m_lock_n == LM) begin m_locked = 0; pf_next = 1; end
        end else begin
          m_locked = 0;
        end
      end else if (dw && bus.D_Lock) begin
        if (LM == 1) pf_next = 1;
        else begin m_locked = 1; m_lock_n = 1; end
      end
      m_pfirst = pf_next;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int nd, run_d, max_d, run_s, max_s;
    bit [9:0] gpat;
    set_p(0, 0, 0, 0);
    set_d(0, 0, 0, 0, 0);
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;

    // Pipeline-only store then load
    set_p(1, 1, 2, 32'hFAAF_FAAF); tick();
    chk("pipe_st_stall", obs_pstall, 0);
    set_p(1, 0, 2, 0); tick();
    chk("pipe_ld_stall", obs_pstall, 0);
    set_p(0, 0, 0, 0); tick();
    chk("pipe_rd_vld", obs_prvld, 1);
    chk("pipe_rd_dat", obs_prdata, 32'hFAAF_FAAF);

    // Starvation under continuous contention
    set_p(1, 0, 3, 0); set_d(1, 0, 0, 4, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      gpat[i] = obs_dgnt;
    end
    chk("starve_pattern", 32'(gpat), 32'b10000_10000);
    set_p(0, 0, 0, 0); set_d(0, 0, 0, 0, 0); tick();

    // Locked debug burst of 20 stores against a requesting pipeline
    nd = 0; run_d = 0; max_d = 0; run_s = 0; max_s = 0;
    set_p(1, 0, 5, 0); set_d(1, 1, 1, 32'd10, 32'h1000_0000);
    for (int i = 0; i < 80 && nd < 20; i++) begin
      tick();
      run_d = obs_dgnt ? run_d + 1 : 0;
      run_s = obs_pstall ? run_s + 1 : 0;
      if (run_d > max_d) max_d = run_d;
      if (run_s > max_s) max_s = run_s;
      if (obs_dgnt) begin
        nd++;
        set_d(nd < 20, 1, 1, 32'd10 + 32'(nd % 8), 32'h1000_0000 + 32'(nd));
      end
    end
    chk("lock_grants", nd, 20);
    chk("lock_max_run", max_d, LM);
    chk("lock_stall_run", max_s, LM);
    set_p(0, 0, 0, 0); set_d(0, 0, 0, 0, 0); tick();

    // Out-of-range debug store then load
    set_d(1, 1, 0, 32'd300, 32'h1234_5678); tick();
    set_d(1, 0, 0, 32'd300, 0); tick();
    chk("oor_err_st", obs_err, 1);
    set_d(0, 0, 0, 0, 0); tick();
    chk("oor_err_ld", obs_err, 1);
    chk("oor_rvld", obs_drvld, 1);
    chk("oor_rdat", obs_drdata, 0);

    // Interleaved loads: pipeline addr 1, debug addr 0
    set_p(1, 1, 1, 32'h0000_1111); tick();
    set_p(1, 1, 0, 32'h0000_2222); tick();
    set_p(1, 0, 1, 0); tick();
    set_p(0, 0, 0, 0); set_d(1, 0, 0, 0, 0); tick();
    chk("il_p_vld", obs_prvld, 1);
    chk("il_p_dat", obs_prdata, 32'h0000_1111);
    set_d(0, 0, 0, 0, 0); tick();
    chk("il_d_vld", obs_drvld, 1);
    chk("il_d_dat", obs_drdata, 32'h0000_2222);
    chk("il_p_off", obs_prvld, 0);

    // Reset in the middle of a load
    set_p(1, 0, 2, 0); tick();
    RST = 1'b0;
    tick();
    chk("rst_p_vld", obs_prvld, 0);
    chk("rst_stall", obs_pstall, 0);
    set_p(0, 0, 0, 0);
    RST = 1'b1;
    tick();
    chk("rst_after_vld", obs_prvld, 0);

    // Random traffic; denied requesters hold their fields
    for (int i = 0; i < 3000; i++) begin
      if (!exp_pstall) begin
        bus.P_Req = ($urandom_range(0, 3) != 0);
        bus.P_W_En = $urandom_range(0, 1);
        bus.P_Control = 3'($urandom_range(0, 7));
        bus.P_Addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(250, 300)) : 32'($urandom_range(0, 9));
        bus.P_W_Data = $urandom;
      end
      if (!exp_ddenied) begin
        bus.D_Req = ($urandom_range(0, 2) == 0);
        bus.D_W_En = $urandom_range(0, 1);
        bus.D_Control = 3'($urandom_range(0, 7));
        bus.D_Addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(250, 300)) : 32'($urandom_range(0, 9));
        bus.D_W_Data = $urandom;
      end
      bus.D_Lock = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
